if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the simplified ARM pipeline; sits directly upstream of the ID stage and drives its if_pc/if_instruction inputs.
- Owns the PC register and a request/response handshake to a variable-latency instruction memory.
- Handles branch redirect from EXE, freeze from hazard detection and flush; contains the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID on reset, flush or bubble.

Ports:
- clk  input  1  pipeline clock, all state on rising edge
- reset  input  1  synchronous, active-high
- freeze  input  1  hazard stall; hold IF/ID register and PC
- flush  input  1  squash IF/ID contents (bubble)
- branch_taken  input  1  redirect request from EXE
- branch_addr  input  32  redirect target, word aligned
- imem_req  output  1  fetch request, one-cycle pulse
- imem_addr  output  32  fetch address, equals current PC when imem_req=1
- imem_rdata  input  32  returned instruction, valid when imem_valid=1
- imem_valid  input  1  response strobe, one pulse per request, at least 1 cycle after imem_req
- if_pc_out  output  32  PC+4 of the instruction in IF/ID
- if_instruction_out  output  32  instruction in IF/ID
- if_valid_out  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (synchronous, overrides everything):
  - pc=RESET_PC; state=REQ; hold buffer cleared.
  - if_pc_out=0, if_instruction_out=NOP_INSTR, if_valid_out=0, imem_req=0 in the reset cycle.
- imem_req and imem_addr are combinational from state: imem_req=1 only in REQ; imem_addr=pc at all times.
- Exactly one request is outstanding at any time.
- State machine:
  - REQ: assert imem_req.
    - branch_taken: pc<=branch_addr; go DRAIN.
    - otherwise: go WAIT.
  - WAIT: request outstanding.
    - imem_valid with branch_taken: discard data; pc<=branch_addr; go REQ.
    - imem_valid with freeze (no branch): latch imem_rdata into hold buffer; go HOLD.
    - imem_valid otherwise: load IF/ID (instr=imem_rdata, pc_out=pc+4, valid=1); pc<=pc+4; go REQ.
    - no imem_valid with branch_taken: pc<=branch_addr; go DRAIN.
    - no imem_valid otherwise: stay.
  - HOLD: fetched word parked, IF/ID frozen.
    - branch_taken: drop buffer; pc<=branch_addr; go REQ.
    - freeze=0: load IF/ID from buffer (pc_out=pc+4, valid=1); pc<=pc+4; go REQ.
    - otherwise: stay.
  - DRAIN: stale response outstanding.
    - further branch_taken: pc<=branch_addr (latest wins); stay.
    - imem_valid: discard data; go REQ. Branch and imem_valid in the same cycle apply both.
- IF/ID register update priority, highest first:
  1. reset.
  2. flush: instr=NOP_INSTR, valid=0, pc_out=0.
  3. freeze: hold all three.
  4. load as listed above.
  5. otherwise bubble: valid=0, instr=NOP_INSTR, pc_out holds.
- Flush does not discard an in-flight fetch; only branch_taken redirects the PC.
- PC arithmetic: 32-bit, +4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 without error.
- Throughput: with 1-cycle memory, one instruction every 2 cycles. Latency from imem_req to if_valid_out=1 is response delay + 1 edge.
- Spurious imem_valid in REQ or HOLD is ignored.

Test Plan:
- Reset then free-run, 1-cycle memory returning addr as data:
  - if_instruction_out sequence 0, 4, 8 with if_pc_out 4, 8, 12, valid every other cycle.
  - imem_addr starts at 32'h0.
- 3-cycle memory latency: imem_req pulses once per 4 cycles; no second request while one is outstanding; data at IF/ID unchanged until next load.
- Freeze across response:
  - freeze=1 for 5 cycles while word 32'hE3A0_1005 returns: IF/ID holds its old value and state is HOLD.
  - On release, IF/ID shows 32'hE3A0_1005 next edge and pc advances by 4.
- Branch during WAIT, branch_addr=32'h100, response 2 cycles later: that response is discarded, next imem_addr=32'h100, and no instruction from the old path reaches if_valid_out.
- Branch coinciding with imem_valid, and two branches in DRAIN (0x200 then 0x300): only 0x300 is fetched next.
- Flush with freeze simultaneously → if_valid_out=0, instr=NOP. Reset asserted mid-WAIT → state REQ, pc=RESET_PC, and the late stale imem_valid is ignored.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The fetch stage drives req/addr; the memory answers with one valid pulse per request.
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        valid;

  modport master (output req, output addr, input rdata, input valid);
  modport slave  (input req, input addr, output rdata, output valid);
endinterface

// File: rtl/if_fetch_stage.sv
// IF stage: owns the PC, runs a single-outstanding fetch handshake to a variable-latency
// instruction memory, and holds the IF/ID pipeline register feeding the ID stage.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             freeze_i,
  input  logic             flush_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_addr_i,
  if_fetch_stage_if.master imem,
  output logic [31:0]      if_pc_o,
  output logic [31:0]      if_instruction_o,
  output logic             if_valid_o
);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] holdBuf_q, holdBuf_d;
  logic [31:0] idPc_q, idPc_d;
  logic [31:0] idInstr_q, idInstr_d;
  logic        idValid_q, idValid_d;
  logic        load;
  logic [31:0] loadData;
  logic [31:0] pcPlus4;

  assign pcPlus4   = pc_q + 32'd4;
  assign imem.req  = (state_q == ST_REQ) && !reset_i;
  assign imem.addr = pc_q;

  // DRAIN waits out a response whose address was abandoned by a redirect.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    holdBuf_d = holdBuf_q;
    load      = 1'b0;
    loadData  = holdBuf_q;
    unique case (state_q)
      ST_REQ: begin
        if (branch_taken_i) begin
          pc_d    = branch_addr_i;
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem.valid) begin
          if (branch_taken_i) begin
            pc_d    = branch_addr_i;
            state_d = ST_REQ;
          end else if (freeze_i) begin
            holdBuf_d = imem.rdata;
            state_d   = ST_HOLD;
          end else begin
            load     = 1'b1;
            loadData = imem.rdata;
            pc_d     = pcPlus4;
            state_d  = ST_REQ;
          end
        end else if (branch_taken_i) begin
          pc_d    = branch_addr_i;
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (branch_taken_i) begin
          pc_d    = branch_addr_i;
          state_d = ST_REQ;
        end else if (!freeze_i) begin
          load     = 1'b1;
          loadData = holdBuf_q;
          pc_d     = pcPlus4;
          state_d  = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (branch_taken_i) begin
          pc_d = branch_addr_i;
        end
        if (imem.valid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // Flush beats freeze beats load; an idle cycle inserts a bubble but keeps pc_out.
  always_comb begin
    idPc_d    = idPc_q;
    idInstr_d = idInstr_q;
    idValid_d = idValid_q;
    if (flush_i) begin
      idPc_d    = 32'h0000_0000;
      idInstr_d = NOP_INSTR;
      idValid_d = 1'b0;
    end else if (freeze_i) begin
      idPc_d    = idPc_q;
      idInstr_d = idInstr_q;
      idValid_d = idValid_q;
    end else if (load) begin
      idPc_d    = pcPlus4;
      idInstr_d = loadData;
      idValid_d = 1'b1;
    end else begin
      idInstr_d = NOP_INSTR;
      idValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC;
      holdBuf_q <= 32'h0000_0000;
      idPc_q    <= 32'h0000_0000;
      idInstr_q <= NOP_INSTR;
      idValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      holdBuf_q <= holdBuf_d;
      idPc_q    <= idPc_d;
      idInstr_q <= idInstr_d;
      idValid_q <= idValid_d;
    end
  end

  assign if_pc_o          = idPc_q;
  assign if_instruction_o = idInstr_q;
  assign if_valid_o       = idValid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a latency-programmable memory plus a flag-based fetch model,
// driven through directed scenarios followed by a randomized run.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  logic        clk;
  logic        reset;
  logic        freeze;
  logic        flush;
  logic        branchTaken;
  logic [31:0] branchAddr;
  logic [31:0] ifPc;
  logic [31:0] ifInstr;
  logic        ifValid;

  if_fetch_stage_if bus ();

  if_fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .freeze_i        (freeze),
    .flush_i         (flush),
    .branch_taken_i  (branchTaken),
    .branch_addr_i   (branchAddr),
    .imem            (bus),
    .if_pc_o         (ifPc),
    .if_instruction_o(ifInstr),
    .if_valid_o      (ifValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycleNo = 0;
  int reqCount = 0;

  // Memory: one response slot, answered lat cycles after the request.
  int          lat = 1;
  bit          slotBusy = 0;
  int          slotDue = 0;
  logic [31:0] slotData;
  bit          overrideEn = 0;
  logic [31:0] overrideWord;
  logic        lastReq;
  logic [31:0] lastAddr;

  // Model: a request is either outstanding, abandoned (stale) or parked, else one may issue.
  bit          mInit = 0;
  logic [31:0] mPc;
  bit          mOut, mStale, mPark;
  logic [31:0] mParkWord;
  logic [31:0] mIdPc, mIdInstr;
  logic        mIdValid;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input logic rst, input logic frz, input logic fl, input logic br,
                           input logic [31:0] ba, input logic v, input logic [31:0] rd);
    logic        ld;
    logic [31:0] word;
    logic [31:0] oldPc;
    if (rst) begin
      mInit = 1; mPc = RESET_PC; mOut = 0; mStale = 0; mPark = 0;
      mIdPc = 32'h0; mIdInstr = NOP_INSTR; mIdValid = 1'b0;
    end else begin
      ld = 0; word = 32'h0; oldPc = mPc;
      if (!mOut && !mStale && !mPark) begin
        if (br) begin mPc = ba; mStale = 1; end
        else mOut = 1;
      end else if (mOut) begin
        if (v) begin
          mOut = 0;
          if (br) mPc = ba;
          else if (frz) begin mPark = 1; mParkWord = rd; end
          else begin ld = 1; word = rd; end
        end else if (br) begin
          mOut = 0; mStale = 1; mPc = ba;
        end
      end else if (mPark) begin
        if (br) begin mPark = 0; mPc = ba; end
        else if (!frz) begin mPark = 0; ld = 1; word = mParkWord; end
      end else begin
        if (br) mPc = ba;
        if (v) mStale = 0;
      end
      if (ld) mPc = oldPc + 32'd4;
      if (fl) begin
        mIdPc = 32'h0; mIdInstr = NOP_INSTR; mIdValid = 1'b0;
      end else if (!frz) begin
        if (ld) begin
          mIdPc = oldPc + 32'd4; mIdInstr = word; mIdValid = 1'b1;
        end else begin
          mIdInstr = NOP_INSTR; mIdValid = 1'b0;
        end
      end
    end
  endtask

  task automatic checkOutput();
    checkValue("if_pc", ifPc, mIdPc);
    checkValue("if_instruction", ifInstr, mIdInstr);
    checkValue("if_valid", {31'h0, ifValid}, {31'h0, mIdValid});
  endtask

  task automatic applyStimulus(input logic rst, input logic frz, input logic fl, input logic br,
                               input logic [31:0] ba, input logic spur);
    logic expReq;
    @(negedge clk);
    reset = rst; freeze = frz; flush = fl; branchTaken = br; branchAddr = ba;
    if (slotBusy && slotDue == cycleNo) begin
      bus.valid = 1'b1; bus.rdata = slotData; slotBusy = 0;
    end else if (spur && !rst && mInit && !mOut && !mStale) begin
      bus.valid = 1'b1; bus.rdata = $urandom;
    end else begin
      bus.valid = 1'b0; bus.rdata = $urandom;
    end
    #1;
    expReq = !rst && mInit && !mOut && !mStale && !mPark;
    checkValue("imem_req", {31'h0, bus.req}, {31'h0, expReq});
    if (mInit) checkValue("imem_addr", bus.addr, mPc);
    lastReq = bus.req; lastAddr = bus.addr;
    if (bus.req) begin
      reqCount++;
      checkValue("single_outstanding", {31'h0, slotBusy}, 32'h0);
      slotBusy = 1; slotDue = cycleNo + lat;
      slotData = overrideEn ? overrideWord : bus.addr;
      overrideEn = 0;
    end
    modelStep(rst, frz, fl, br, ba, bus.valid, bus.rdata);
    @(posedge clk);
    #1;
    checkOutput();
    cycleNo++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic settle();
    for (int i = 0; i < 30 && (mOut || mStale || mPark); i++) idle(1);
  endtask

  logic [31:0] gotInstr [3];
  logic [31:0] gotPc [3];
  int          gotCyc [3];
  int          gotN;
  int          r0;
  logic [31:0] addrA;
  logic [31:0] oldInstr;
  bit          sawValid;
  logic [31:0] rnd;

  initial begin
    reset = 1'b1; freeze = 1'b0; flush = 1'b0; branchTaken = 1'b0; branchAddr = 32'h0;
    bus.valid = 1'b0; bus.rdata = 32'h0;

    // Reset
    applyStimulus(1, 0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 0, 32'h0, 0);
    checkValue("reset_valid", {31'h0, ifValid}, 32'h0);
    checkValue("reset_instr", ifInstr, NOP_INSTR);
    checkValue("reset_pc", ifPc, 32'h0);

    // Free run, 1-cycle memory returning addr as data
    lat = 1; gotN = 0;
    for (int k = 0; k < 3; k++) begin gotInstr[k] = 'x; gotPc[k] = 'x; gotCyc[k] = -10; end
    idle(1);
    checkValue("first_addr", lastAddr, 32'h0);
    for (int i = 0; i < 12 && gotN < 3; i++) begin
      idle(1);
      if (ifValid) begin
        gotInstr[gotN] = ifInstr; gotPc[gotN] = ifPc; gotCyc[gotN] = cycleNo; gotN++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      checkValue("freerun_instr", gotInstr[k], 32'(k * 4));
      checkValue("freerun_pc", gotPc[k], 32'(k * 4 + 4));
    end
    checkValue("freerun_spacing", 32'(gotCyc[1] - gotCyc[0]), 32'd2);
    checkValue("freerun_spacing2", 32'(gotCyc[2] - gotCyc[1]), 32'd2);

    // 3-cycle memory: one request per 4 cycles
    settle(); lat = 3; r0 = reqCount;
    idle(8);
    checkValue("lat3_req_count", 32'(reqCount - r0), 32'd2);

    // Freeze across the response
    settle(); lat = 2; overrideEn = 1; overrideWord = 32'hE3A0_1005;
    idle(1);
    addrA = lastAddr; oldInstr = ifInstr;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 0, 32'h0, 0);
      checkValue("freeze_hold_instr", ifInstr, oldInstr);
    end
    idle(1);
    checkValue("unfreeze_instr", ifInstr, 32'hE3A0_1005);
    checkValue("unfreeze_valid", {31'h0, ifValid}, 32'h1);
    checkValue("unfreeze_pc", ifPc, addrA + 32'd4);
    idle(1);
    checkValue("unfreeze_next_addr", lastAddr, addrA + 32'd4);

    // Branch during WAIT, response 2 cycles later
    settle(); lat = 3; sawValid = 0;
    idle(1); sawValid |= ifValid;
    applyStimulus(0, 0, 0, 1, 32'h100, 0); sawValid |= ifValid;
    idle(1); sawValid |= ifValid;
    idle(1); sawValid |= ifValid;
    checkValue("branch_no_stale_valid", {31'h0, sawValid}, 32'h0);
    idle(1);
    checkValue("branch_req", {31'h0, lastReq}, 32'h1);
    checkValue("branch_addr", lastAddr, 32'h100);
    idle(3);
    checkValue("branch_instr", ifInstr, 32'h100);

    // Branch with imem_valid, then two branches in DRAIN
    settle(); lat = 1;
    idle(1);
    applyStimulus(0, 0, 0, 1, 32'h180, 0);
    checkValue("coincide_no_load", {31'h0, ifValid}, 32'h0);
    lat = 3;
    idle(1);
    checkValue("coincide_addr", lastAddr, 32'h180);
    applyStimulus(0, 0, 0, 1, 32'h200, 0);
    applyStimulus(0, 0, 0, 1, 32'h300, 0);
    idle(2);
    checkValue("drain_latest_addr", lastAddr, 32'h300);
    idle(3);
    checkValue("drain_latest_instr", ifInstr, 32'h300);

    // PC wrap
    settle(); lat = 1;
    applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    idle(2);
    checkValue("wrap_addr", lastAddr, 32'hFFFF_FFFC);
    idle(1);
    checkValue("wrap_pc_out", ifPc, 32'h0);
    idle(1);
    checkValue("wrap_next_addr", lastAddr, 32'h0);

    // Flush together with freeze
    settle(); lat = 1;
    idle(2);
    checkValue("preflush_valid", {31'h0, ifValid}, 32'h1);
    applyStimulus(0, 1, 1, 0, 32'h0, 0);
    checkValue("flush_valid", {31'h0, ifValid}, 32'h0);
    checkValue("flush_instr", ifInstr, NOP_INSTR);
    checkValue("flush_pc", ifPc, 32'h0);

    // Reset mid-WAIT; the stale response lands in REQ
    settle(); lat = 3; overrideEn = 1; overrideWord = 32'hDEAD_BEEF;
    idle(2);
    applyStimulus(1, 0, 0, 0, 32'h0, 0);
    idle(1);
    checkValue("postreset_req", {31'h0, lastReq}, 32'h1);
    checkValue("postreset_addr", lastAddr, RESET_PC);
    idle(3);
    checkValue("postreset_instr", ifInstr, 32'h0);
    checkValue("postreset_valid", {31'h0, ifValid}, 32'h1);

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 4);
      rnd = $urandom; rnd[1:0] = 2'b00;
      applyStimulus(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 11) == 0), rnd, ($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
